// File: rtl/mem_wb_pkg.sv
// Shared constants, stage-control encoding and helpers for the MEM->WB pipeline register.
package mem_wb_pkg;

  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [31:0] NOP_REG_ADDR = 32'd0;
  localparam logic [63:0] ZERO_WORD    = 64'd0;

  typedef enum logic [1:0] {
    CTL_RESET,
    CTL_BUBBLE,
    CTL_ADVANCE,
    CTL_HOLD
  } stage_ctl_e;

  function automatic logic [2:0] countOnes(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/mem_wb_if.sv
// MEM->WB bus: memory-stage lanes in, write-back lanes out.
// Counter signals exist only when MEM_WB_PERF_EN is defined.
interface mem_wb_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int LANES   = 1,
  parameter int STALL_W = 6
`ifdef MEM_WB_PERF_EN
  , parameter int CNT_W = 32
`endif
) ();

  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic [LANES-1:0]        mem_valid;
  logic [LANES*DATA_W-1:0] mem_wdata;
  logic [LANES*ADDR_W-1:0] mem_wd;
  logic [LANES-1:0]        mem_wreg;

  logic [LANES-1:0]        wb_valid;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0]        retire_cnt;
  logic [CNT_W-1:0]        bubble_cnt;
`endif

  modport master (
    output stall, flush, mem_valid, mem_wdata, mem_wd, mem_wreg,
    input  wb_valid, wb_wdata, wb_wd, wb_wreg
`ifdef MEM_WB_PERF_EN
    , input retire_cnt, bubble_cnt
`endif
  );

  modport slave (
    input  stall, flush, mem_valid, mem_wdata, mem_wd, mem_wreg,
    output wb_valid, wb_wdata, wb_wd, wb_wreg
`ifdef MEM_WB_PERF_EN
    , output retire_cnt, bubble_cnt
`endif
  );

endinterface

// File: rtl/mem_wb_lane.sv
// One write-back lane register, driven by the stage-wide decoded control.
module mem_wb_lane
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  stage_ctl_e        i_ctl,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_wd,
  input  logic              i_wreg,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_wdata,
  output logic [ADDR_W-1:0] o_wd,
  output logic              o_wreg
);

  logic              r_valid;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_wd;
  logic              r_wreg;

  // Reset and bubble both leave a NOP in the lane; hold simply keeps state.
  always_ff @(posedge clk) begin
    case (i_ctl)
      CTL_RESET, CTL_BUBBLE: begin
        r_valid <= 1'b0;
        r_wdata <= ZERO_WORD[DATA_W-1:0];
        r_wd    <= NOP_REG_ADDR[ADDR_W-1:0];
        r_wreg  <= WriteDisable;
      end
      CTL_ADVANCE: begin
        r_valid <= i_valid;
        r_wdata <= i_wdata;
        r_wd    <= i_wd;
        r_wreg  <= i_wreg;
      end
      default: ;
    endcase
  end

  assign o_valid = r_valid;
  assign o_wdata = r_wdata;
  assign o_wd    = r_wd;
  assign o_wreg  = r_wreg;

endmodule

// File: rtl/mem_wb_stage.sv
// Multi-lane MEM->WB pipeline register with flush, x0 suppression and conflict filtering.
// Optional retire/bubble counters are enabled by defining MEM_WB_PERF_EN.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LANES     = 1,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 4
`ifdef MEM_WB_PERF_EN
  , parameter int CNT_W   = 32
`endif
) (
  input logic     clk,
  input logic     rst,
  mem_wb_if.slave bus
);

  stage_ctl_e              w_ctl;
  logic [LANES-1:0]        w_wreg_raw;
  logic [LANES-1:0]        w_wreg_flt;
  logic [LANES-1:0]        w_valid;
  logic [LANES*DATA_W-1:0] w_wdata;
  logic [LANES*ADDR_W-1:0] w_wd;
  logic [LANES-1:0]        w_wreg;

  // Flush outranks the hold, so a held stage can still be emptied.
  always_comb begin
    w_ctl = CTL_HOLD;
    if (rst)
      w_ctl = CTL_RESET;
    else if (bus.flush ||
             (bus.stall[STAGE_IDX] == Stop && bus.stall[STAGE_IDX+1] == NoStop))
      w_ctl = CTL_BUBBLE;
    else if (bus.stall[STAGE_IDX] == NoStop)
      w_ctl = CTL_ADVANCE;
  end

  // Older lanes lose a same-destination write to the youngest lane.
  always_comb begin
    w_wreg_raw = '0;
    for (int i = 0; i < LANES; i++) begin
      w_wreg_raw[i] = (bus.mem_wreg[i] == WriteEnable) && bus.mem_valid[i] &&
                      (bus.mem_wd[i*ADDR_W +: ADDR_W] != NOP_REG_ADDR[ADDR_W-1:0]);
    end
    w_wreg_flt = w_wreg_raw;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_wreg_raw[i] && w_wreg_raw[j] &&
            bus.mem_wd[i*ADDR_W +: ADDR_W] == bus.mem_wd[j*ADDR_W +: ADDR_W])
          w_wreg_flt[i] = WriteDisable;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_wb_lane #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .i_ctl   (w_ctl),
      .i_valid (bus.mem_valid[g]),
      .i_wdata (bus.mem_wdata[g*DATA_W +: DATA_W]),
      .i_wd    (bus.mem_wd[g*ADDR_W +: ADDR_W]),
      .i_wreg  (w_wreg_flt[g]),
      .o_valid (w_valid[g]),
      .o_wdata (w_wdata[g*DATA_W +: DATA_W]),
      .o_wd    (w_wd[g*ADDR_W +: ADDR_W]),
      .o_wreg  (w_wreg[g])
    );
  end

  assign bus.wb_valid = w_valid;
  assign bus.wb_wdata = w_wdata;
  assign bus.wb_wd    = w_wd;
  assign bus.wb_wreg  = w_wreg;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else if (w_ctl == CTL_BUBBLE) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else if (w_ctl == CTL_ADVANCE) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(countOnes(4'(bus.mem_valid)));
    end
  end

  assign bus.retire_cnt = r_retire_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage (LANES=2) against a rule-level reference model.
// Counter checks are compiled in when MEM_WB_PERF_EN is defined.
module tb_mem_wb_stage;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int LANES     = 2;
  localparam int STALL_W   = 6;
  localparam int STAGE_IDX = 4;
  localparam int CNT_W     = 32;
  localparam int ST_W      = 2*LANES + LANES*DATA_W + LANES*ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [LANES-1:0]        mValid;
  logic [LANES*DATA_W-1:0] mWdata;
  logic [LANES*ADDR_W-1:0] mWd;
  logic [LANES-1:0]        mWreg;
  logic [CNT_W-1:0]        mRetire;
  logic [CNT_W-1:0]        mBubble;

  mem_wb_if #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .LANES   (LANES),
    .STALL_W (STALL_W)
  ) bus ();

  mem_wb_stage #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LANES     (LANES),
    .STALL_W   (STALL_W),
    .STAGE_IDX (STAGE_IDX)
`ifdef MEM_WB_PERF_EN
    , .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no_finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [ST_W-1:0] dutState();
    return {bus.wb_valid, bus.wb_wdata, bus.wb_wd, bus.wb_wreg};
  endfunction

  function automatic logic [ST_W-1:0] modelState();
    return {mValid, mWdata, mWd, mWreg};
  endfunction

  task automatic applyStimulus(input logic [STALL_W-1:0] s, input logic f,
                               input logic [LANES-1:0] v, input logic [LANES*DATA_W-1:0] d,
                               input logic [LANES*ADDR_W-1:0] w, input logic [LANES-1:0] we);
    bus.stall     = s;
    bus.flush     = f;
    bus.mem_valid = v;
    bus.mem_wdata = d;
    bus.mem_wd    = w;
    bus.mem_wreg  = we;
  endtask

  // Reference: each destination register is claimed by the youngest eligible lane.
  task automatic modelEdge();
    logic [31:0]       claimed;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      mValid = '0; mWdata = '0; mWd = '0; mWreg = '0;
      mRetire = '0; mBubble = '0;
    end else if (bus.flush || (bus.stall[STAGE_IDX] && !bus.stall[STAGE_IDX+1])) begin
      mValid = '0; mWdata = '0; mWd = '0; mWreg = '0;
      mBubble = mBubble + 1;
    end else if (!bus.stall[STAGE_IDX]) begin
      mValid  = bus.mem_valid;
      mWdata  = bus.mem_wdata;
      mWd     = bus.mem_wd;
      mWreg   = '0;
      claimed = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
        a = bus.mem_wd[i*ADDR_W +: ADDR_W];
        if (bus.mem_valid[i] && bus.mem_wreg[i] && a != 0 && !claimed[a]) begin
          mWreg[i]   = 1'b1;
          claimed[a] = 1'b1;
        end
      end
      mRetire = mRetire + CNT_W'($countones(bus.mem_valid));
    end
  endtask

  task automatic cycle();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(6'b000000, 1'b0, 2'b11, {$urandom, $urandom}, {5'd3, 5'd9}, 2'b11);
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (dutState() !== '0) begin
        errors++;
        $display("[TB] FAIL reset_state%0d: got %h expected 0", k, dutState());
      end
`ifdef MEM_WB_PERF_EN
      checks++;
      if ({bus.retire_cnt, bus.bubble_cnt} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_counters%0d: got %h/%h expected 0/0", k, bus.retire_cnt, bus.bubble_cnt);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_advance_hold();
    logic [ST_W-1:0] held;
    applyStimulus(6'b000000, 1'b0, 2'b01, {32'h0, 32'hDEADBEEF}, {5'd0, 5'd5}, 2'b01);
    cycle();
    checks++;
    if ({bus.wb_valid[0], bus.wb_wdata[31:0], bus.wb_wd[4:0], bus.wb_wreg[0]} !==
        {1'b1, 32'hDEADBEEF, 5'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL advance_lane0: got %h expected deadbeef wd=5 wreg=1", dutState());
    end
    held = modelState();
    applyStimulus(6'b110000, 1'b0, 2'b11, {$urandom, $urandom}, {5'd11, 5'd12}, 2'b11);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (dutState() !== held) begin
        errors++;
        $display("[TB] FAIL hold%0d: got %h expected %h", k, dutState(), held);
      end
    end
  endtask

  task automatic test_bubble();
    logic [CNT_W-1:0] bub0;
    bub0 = mBubble;
    applyStimulus(6'b010000, 1'b0, 2'b11, {$urandom, $urandom}, {5'd4, 5'd6}, 2'b11);
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (dutState() !== '0) begin
        errors++;
        $display("[TB] FAIL bubble%0d: got %h expected 0", k, dutState());
      end
`ifdef MEM_WB_PERF_EN
      checks++;
      if (bus.bubble_cnt !== bub0 + CNT_W'(k + 1)) begin
        errors++;
        $display("[TB] FAIL bubble_cnt%0d: got %0d expected %0d", k, bus.bubble_cnt, bub0 + CNT_W'(k + 1));
      end
`endif
    end
  endtask

  task automatic test_flush_hold();
    applyStimulus(6'b000000, 1'b0, 2'b11, {$urandom, $urandom | 32'h1}, {5'd1, 5'd2}, 2'b11);
    cycle();
    checks++;
    if (dutState() !== modelState()) begin
      errors++;
      $display("[TB] FAIL flush_preload: got %h expected %h", dutState(), modelState());
    end
    applyStimulus(6'b110000, 1'b1, 2'b11, {$urandom, $urandom}, {5'd3, 5'd4}, 2'b11);
    cycle();
    checks++;
    if (dutState() !== '0) begin
      errors++;
      $display("[TB] FAIL flush_in_hold: got %h expected 0", dutState());
    end
  endtask

  task automatic test_x0();
    applyStimulus(6'b000000, 1'b0, 2'b01, {32'h0, 32'h12345678}, {5'd0, 5'd0}, 2'b01);
    cycle();
    checks++;
    if ({bus.wb_valid[0], bus.wb_wreg[0], bus.wb_wdata[31:0]} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL x0_suppress: got %h expected valid=1 wreg=0 data=12345678", dutState());
    end
  endtask

  task automatic test_conflict();
    logic [CNT_W-1:0] ret0;
    ret0 = mRetire;
    applyStimulus(6'b000000, 1'b0, 2'b11, {32'hAAAA5555, 32'h00001234}, {5'd7, 5'd7}, 2'b11);
    cycle();
    checks++;
    if (bus.wb_wreg !== 2'b10) begin
      errors++;
      $display("[TB] FAIL conflict_wreg: got %b expected 10", bus.wb_wreg);
    end
`ifdef MEM_WB_PERF_EN
    checks++;
    if (bus.retire_cnt !== ret0 + CNT_W'(2)) begin
      errors++;
      $display("[TB] FAIL conflict_retire: got %0d expected %0d", bus.retire_cnt, ret0 + CNT_W'(2));
    end
`endif
  endtask

  task automatic test_random();
    logic [LANES*ADDR_W-1:0] wd;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < LANES; i++) wd[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
      applyStimulus(STALL_W'($urandom), ($urandom_range(0, 9) == 0), LANES'($urandom),
                    {$urandom, $urandom}, wd, LANES'($urandom));
      cycle();
      checks++;
      if (dutState() !== modelState()) begin
        errors++;
        $display("[TB] FAIL random%0d: got %h expected %h", n, dutState(), modelState());
      end
`ifdef MEM_WB_PERF_EN
      checks++;
      if ({bus.retire_cnt, bus.bubble_cnt} !== {mRetire, mBubble}) begin
        errors++;
        $display("[TB] FAIL random_cnt%0d: got %0d/%0d expected %0d/%0d", n,
                 bus.retire_cnt, bus.bubble_cnt, mRetire, mBubble);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    mValid = '0; mWdata = '0; mWd = '0; mWreg = '0;
    mRetire = '0; mBubble = '0;
    test_reset();
    test_advance_hold();
    test_bubble();
    test_flush_hold();
    test_x0();
    test_conflict();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
